ball_engine: RTL and testbench

//  Parametrised ball motion engine for pong: fixed-point position, LUT sin/cos direction, serve FSM.

---
 rtl/ball_engine_pkg.sv | 30 +++
 rtl/ball_engine_if.sv | 37 +++
 rtl/ball_engine_trig.sv | 68 ++++++
 rtl/ball_engine.sv | 175 +++++++++++++++++
 tb/tb_ball_engine.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/ball_engine_pkg.sv
// Shared types and helpers for the pong ball engine (FSM states, trig amplitude, centre/reflection math).
// Latency: n/a (package only).
// Backpressure: n/a.
package pong_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    MOVE = 1'b1
  } state_e;

  // Peak magnitude of the registered sin/cos values (signed 8-bit).
  localparam int TRIG_AMP = 127;
  localparam int TRIG_W   = 8;

  // Midpoint of a coordinate that has `bits` screen bits above `frac` fraction bits.
  function automatic logic [31:0] centre(input int bits, input int frac);
    return 32'(1) << (bits + frac - 1);
  endfunction

  // Bounce off a left/right wall: theta -> HALF - theta. Caller truncates to its theta width.
  function automatic logic [15:0] reflect_x(input logic [15:0] th, input int tw);
    return (16'(1) << (tw - 1)) - th;
  endfunction

  // Bounce off a top/bottom wall: theta -> -theta. Caller truncates to its theta width.
  function automatic logic [15:0] reflect_y(input logic [15:0] th);
    return 16'(0) - th;
  endfunction

endpackage

// File: rtl/ball_engine_if.sv
// Game-side bundle of the ball engine: controller inputs (step/serve/speed/paddles) and display/score outputs.
// Latency: n/a (wires only).
// Backpressure: none; step is a plain enable, the engine drops ticks it cannot use.
interface ball_engine_if #(
  parameter int X_BITS      = 4,
  parameter int Y_BITS      = 4,
  parameter int THETA_WIDTH = 6,
  parameter int SPEED_WIDTH = 5
) ();

  logic                   step;
  logic                   serve;
  logic [THETA_WIDTH-1:0] serve_theta;
  logic [SPEED_WIDTH-1:0] speed;
  logic [Y_BITS-1:0]      paddle_l_y;
  logic [Y_BITS-1:0]      paddle_r_y;
  logic [X_BITS-1:0]      x;
  logic [Y_BITS-1:0]      y;
  logic [THETA_WIDTH-1:0] theta;
  logic                   active;
  logic                   bounce;
  logic                   goal_l;
  logic                   goal_r;

  // Game controller side.
  modport master (
    output step, serve, serve_theta, speed, paddle_l_y, paddle_r_y,
    input  x, y, theta, active, bounce, goal_l, goal_r
  );

  // Ball engine side.
  modport slave (
    input  step, serve, serve_theta, speed, paddle_l_y, paddle_r_y,
    output x, y, theta, active, bounce, goal_l, goal_r
  );

endinterface

// File: rtl/ball_engine_trig.sv
// Quarter-wave sin/cos lookup for the ball direction; theta_i -> signed 8-bit sin_o/cos_o.
// Latency: 1 clk (outputs registered).
// Backpressure: none; recomputed every clk.
// Ports: clk, reset_n (async active-low), theta_i (direction), sin_o/cos_o (registered, +/-TRIG_AMP).
module ball_trig
  import pong_pkg::*;
#(
  parameter int THETA_WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [THETA_WIDTH-1:0]   theta_i,
  output logic signed [TRIG_W-1:0] sin_o,
  output logic signed [TRIG_W-1:0] cos_o
);

  // The ROM is built for 64 steps per turn; other widths are mapped onto that phase.
  logic [5:0] ph;

  if (THETA_WIDTH >= 6) begin : g_trunc
    assign ph = theta_i[THETA_WIDTH-1 -: 6];
  end else begin : g_pad
    assign ph = 6'(theta_i) << (6 - THETA_WIDTH);
  end

  // round(TRIG_AMP * sin(i * 2pi / 64)) for i = 0..16.
  function automatic logic [7:0] quarter(input logic [4:0] i);
    logic [7:0] v;
    case (i)
      5'd0:    v = 8'd0;
      5'd1:    v = 8'd12;
      5'd2:    v = 8'd25;
      5'd3:    v = 8'd37;
      5'd4:    v = 8'd49;
      5'd5:    v = 8'd60;
      5'd6:    v = 8'd71;
      5'd7:    v = 8'd81;
      5'd8:    v = 8'd90;
      5'd9:    v = 8'd98;
      5'd10:   v = 8'd106;
      5'd11:   v = 8'd112;
      5'd12:   v = 8'd117;
      5'd13:   v = 8'd122;
      5'd14:   v = 8'd125;
      5'd15:   v = 8'd126;
      default: v = 8'(TRIG_AMP);
    endcase
    return v;
  endfunction

  // Odd quadrants read the table mirrored, the second half-turn is negated.
  function automatic logic [7:0] sin_of(input logic [5:0] p);
    logic [7:0] mag;
    mag = p[4] ? quarter(5'd16 - {1'b0, p[3:0]}) : quarter({1'b0, p[3:0]});
    return p[5] ? (8'd0 - mag) : mag;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sin_o <= '0;
      cos_o <= '0;
    end else begin
      sin_o <= $signed(sin_of(ph));
      cos_o <= $signed(sin_of(ph + 6'd16));
    end
  end

endmodule

// File: rtl/ball_engine.sv
// Pong ball motion engine: serve FSM, fixed-point position, wall/paddle reflection, optional curving.
// Latency: outputs registered; an accepted step shows on x/y/theta/pulses 1 clk later.
// Backpressure: none; a step arriving while sin/cos are stale (1 clk after a theta change) is dropped.
// Ports: clk, reset_n (async active-low), bus (ball_engine_if.slave: step/serve/serve_theta/speed/
//        paddle_l_y/paddle_r_y in; x/y/theta/active/bounce/goal_l/goal_r out).
module ball_engine
  import pong_pkg::*;
#(
  parameter int X_BITS       = 4,
  parameter int Y_BITS       = 4,
  parameter int FRAC_BITS    = 17,
  parameter int THETA_WIDTH  = 6,
  parameter int SPEED_WIDTH  = 5,
  parameter int PADDLE_LEN   = 4,
  parameter int CURVE_PERIOD = 500
) (
  input logic          clk,
  input logic          reset_n,
  ball_engine_if.slave bus
);

  localparam int HW = X_BITS + FRAC_BITS;
  localparam int VW = Y_BITS + FRAC_BITS;
  localparam int PW = TRIG_W + SPEED_WIDTH;
  localparam int CW = (CURVE_PERIOD > 1) ? $clog2(CURVE_PERIOD) : 1;

  localparam logic [HW-1:0]          HOR_C  = HW'(centre(X_BITS, FRAC_BITS));
  localparam logic [VW-1:0]          VERT_C = VW'(centre(Y_BITS, FRAC_BITS));
  localparam logic [THETA_WIDTH-1:0] HALF   = THETA_WIDTH'(1) << (THETA_WIDTH - 1);

  state_e                 state_q, state_d;
  logic [HW-1:0]          hor_q, hor_d;
  logic [VW-1:0]          vert_q, vert_d;
  logic [THETA_WIDTH-1:0] theta_q, theta_d;
  logic [CW-1:0]          curve_q, curve_d;
  logic                   trig_valid_q;
  logic                   bounce_q, bounce_d;
  logic                   goal_l_q, goal_l_d;
  logic                   goal_r_q, goal_r_d;

  logic signed [TRIG_W-1:0] sin_s, cos_s;

  ball_trig #(
    .THETA_WIDTH(THETA_WIDTH)
  ) u_trig (
    .clk    (clk),
    .reset_n(reset_n),
    .theta_i(theta_q),
    .sin_o  (sin_s),
    .cos_o  (cos_s)
  );

  // Signed velocity, then sign-extended into one extra MSB above the position.
  logic signed [PW-1:0] spd_e, cos_e, sin_e, dx_p, dy_p;
  logic signed [HW:0]   dx_e, nx;
  logic signed [VW:0]   dy_e, ny;

  assign spd_e = $signed({{TRIG_W{bus.speed[SPEED_WIDTH-1]}}, bus.speed});
  assign cos_e = $signed({{SPEED_WIDTH{cos_s[TRIG_W-1]}}, cos_s});
  assign sin_e = $signed({{SPEED_WIDTH{sin_s[TRIG_W-1]}}, sin_s});
  assign dx_p  = cos_e * spd_e;
  assign dy_p  = sin_e * spd_e;
  assign dx_e  = $signed({{(HW + 1 - PW){dx_p[PW-1]}}, dx_p});
  assign dy_e  = $signed({{(VW + 1 - PW){dy_p[PW-1]}}, dy_p});
  assign nx    = $signed({1'b0, hor_q}) + dx_e;
  assign ny    = $signed({1'b0, vert_q}) + dy_e;

  // A step is far smaller than the field, so both underflow and overflow land in the extra MSB.
  logic x_oor, y_oor;
  assign x_oor = nx[HW];
  assign y_oor = ny[VW];

  // Paddle window on the side the ball is heading to; the +1 bit keeps pad+LEN from wrapping.
  logic [Y_BITS-1:0] y_cur, pad_y;
  logic              hit;
  assign y_cur = vert_q[VW-1 -: Y_BITS];
  assign pad_y = dx_p[PW-1] ? bus.paddle_l_y : bus.paddle_r_y;
  assign hit   = ({1'b0, y_cur} >= {1'b0, pad_y}) &&
                 ({1'b0, y_cur} <  ({1'b0, pad_y} + (Y_BITS + 1)'(PADDLE_LEN)));

  logic accept, curve_wrap;
  assign accept     = (state_q == MOVE) && bus.step && trig_valid_q;
  assign curve_wrap = (CURVE_PERIOD != 0) && (curve_q == CW'(CURVE_PERIOD - 1));

  always_comb begin
    state_d  = state_q;
    hor_d    = hor_q;
    vert_d   = vert_q;
    theta_d  = theta_q;
    curve_d  = curve_q;
    bounce_d = 1'b0;
    goal_l_d = 1'b0;
    goal_r_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.serve) begin
          state_d = MOVE;
          hor_d   = HOR_C;
          vert_d  = VERT_C;
          theta_d = bus.serve_theta;
        end
      end

      MOVE: begin
        if (accept) begin
          if (CURVE_PERIOD != 0) begin
            curve_d = curve_wrap ? '0 : curve_q + CW'(1);
          end

          if (x_oor && !hit) begin
            // Miss beats any simultaneous top/bottom edge: score, no bounce.
            goal_l_d = !dx_p[PW-1];
            goal_r_d = dx_p[PW-1];
            state_d  = IDLE;
            hor_d    = HOR_C;
            vert_d   = VERT_C;
          end else begin
            if (!x_oor) hor_d  = nx[HW-1:0];
            if (!y_oor) vert_d = ny[VW-1:0];

            if (x_oor && y_oor) begin
              theta_d  = theta_q + HALF;
              bounce_d = 1'b1;
            end else if (x_oor) begin
              theta_d  = THETA_WIDTH'(reflect_x(16'(theta_q), THETA_WIDTH));
              bounce_d = 1'b1;
            end else if (y_oor) begin
              theta_d  = THETA_WIDTH'(reflect_y(16'(theta_q)));
              bounce_d = 1'b1;
            end else if (curve_wrap) begin
              theta_d = theta_q + THETA_WIDTH'(1);
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      hor_q        <= HOR_C;
      vert_q       <= VERT_C;
      theta_q      <= '0;
      curve_q      <= '0;
      trig_valid_q <= 1'b0;
      bounce_q     <= 1'b0;
      goal_l_q     <= 1'b0;
      goal_r_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      hor_q        <= hor_d;
      vert_q       <= vert_d;
      theta_q      <= theta_d;
      curve_q      <= curve_d;
      // sin/cos follow theta one clk late, so they are stale for the clk after any change.
      trig_valid_q <= (theta_d == theta_q);
      bounce_q     <= bounce_d;
      goal_l_q     <= goal_l_d;
      goal_r_q     <= goal_r_d;
    end
  end

  assign bus.x      = hor_q[HW-1 -: X_BITS];
  assign bus.y      = vert_q[VW-1 -: Y_BITS];
  assign bus.theta  = theta_q;
  assign bus.active = (state_q == MOVE);
  assign bus.bounce = bounce_q;
  assign bus.goal_l = goal_l_q;
  assign bus.goal_r = goal_r_q;

endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine: reset, wall hit, goal, corner hit, stale-trig drop, curving.
// Latency: n/a.
// Backpressure: n/a.
module tb_ball_engine;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic              stp  = 1'b0;
  logic              srv1 = 1'b0;
  logic              srv2 = 1'b0;
  logic [5:0]        st1  = 6'd0;
  logic [4:0]        spd1 = 5'd0;
  logic [3:0]        pl1  = 4'd6;
  logic [3:0]        pr1  = 4'd6;

  int n_vec    = 0;
  int n_err    = 0;
  int n_bounce = 0;
  int b0;

  ball_engine_if #(.X_BITS(4), .Y_BITS(4), .THETA_WIDTH(6), .SPEED_WIDTH(5)) if1 ();
  ball_engine_if #(.X_BITS(4), .Y_BITS(4), .THETA_WIDTH(6), .SPEED_WIDTH(5)) if2 ();

  assign if1.step        = stp;
  assign if1.serve       = srv1;
  assign if1.serve_theta = st1;
  assign if1.speed       = spd1;
  assign if1.paddle_l_y  = pl1;
  assign if1.paddle_r_y  = pr1;

  assign if2.step        = stp;
  assign if2.serve       = srv2;
  assign if2.serve_theta = 6'd0;
  assign if2.speed       = 5'd0;
  assign if2.paddle_l_y  = 4'd6;
  assign if2.paddle_r_y  = 4'd6;

  ball_engine #(.X_BITS(4), .Y_BITS(4), .FRAC_BITS(17), .THETA_WIDTH(6), .SPEED_WIDTH(5),
                .PADDLE_LEN(4), .CURVE_PERIOD(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1));

  ball_engine #(.X_BITS(4), .Y_BITS(4), .FRAC_BITS(17), .THETA_WIDTH(6), .SPEED_WIDTH(5),
                .PADDLE_LEN(4), .CURVE_PERIOD(4)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(if2));

  always @(posedge clk) if (if1.bounce === 1'b1) n_bounce <= n_bounce + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted-step slot: step high for one edge, then three idle clks.
  task automatic do_step(input int n);
    for (int i = 0; i < n; i++) begin
      stp = 1'b1;
      tick();
      stp = 1'b0;
      tick();
      tick();
      tick();
    end
  endtask

  task automatic serve1(input logic [5:0] th);
    st1  = th;
    srv1 = 1'b1;
    tick();
    srv1 = 1'b0;
    tick();
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    // Reset asserted with no clock edge yet.
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_x", 32'(if1.x), 32'd8);
    chk("rst_y", 32'(if1.y), 32'd8);
    chk("rst_theta", 32'(if1.theta), 32'd0);
    chk("rst_active", 32'(if1.active), 32'd0);
    chk("rst_pulses", 32'({if1.bounce, if1.goal_l, if1.goal_r}), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Rightward serve, right paddle at rows 6..9 covers y=8.
    spd1 = 5'd15;
    pl1  = 4'd6;
    pr1  = 4'd6;
    serve1(6'd0);
    chk("t2_active", 32'(if1.active), 32'd1);
    chk("t2_theta0", 32'(if1.theta), 32'd0);
    do_step(550);
    chk("t2_x550", 32'(if1.x), 32'd15);
    chk("t2_y550", 32'(if1.y), 32'd8);
    chk("t2_nobounce", 32'(n_bounce), 32'd0);
    stp = 1'b1;
    tick();
    stp = 1'b0;
    chk("t2_theta_hit", 32'(if1.theta), 32'd32);
    chk("t2_bounce_hi", 32'(if1.bounce), 32'd1);
    chk("t2_x_held", 32'(if1.x), 32'd15);
    tick();
    chk("t2_bounce_lo", 32'(if1.bounce), 32'd0);
    chk("t2_bounce_cnt", 32'(n_bounce), 32'd1);
    // Serve while moving must not touch theta.
    serve1(6'd5);
    chk("t2_serve_ign", 32'(if1.theta), 32'd32);
    chk("t2_still_act", 32'(if1.active), 32'd1);
    // Async reset mid-rally, observed before any clock edge.
    reset_n = 1'b0;
    #1;
    chk("t2_arst_x", 32'(if1.x), 32'd8);
    chk("t2_arst_act", 32'(if1.active), 32'd0);
    chk("t2_arst_th", 32'(if1.theta), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Right paddle at rows 0..3 misses y=8: left player scores.
    pr1 = 4'd0;
    b0  = n_bounce;
    serve1(6'd0);
    do_step(550);
    stp = 1'b1;
    tick();
    stp = 1'b0;
    chk("t3_goal_l", 32'(if1.goal_l), 32'd1);
    chk("t3_goal_r", 32'(if1.goal_r), 32'd0);
    chk("t3_bounce", 32'(if1.bounce), 32'd0);
    chk("t3_active", 32'(if1.active), 32'd0);
    chk("t3_xy", 32'({if1.x, if1.y}), 32'h88);
    tick();
    chk("t3_goal_lo", 32'(if1.goal_l), 32'd0);
    chk("t3_nobounce", 32'(n_bounce - b0), 32'd0);

    // 45 degree serve, corner reached on x and y together; paddle at rows 12..15.
    pr1 = 4'd12;
    serve1(6'd8);
    chk("t4_active", 32'(if1.active), 32'd1);
    chk("t4_theta", 32'(if1.theta), 32'd8);
    b0 = n_bounce;
    do_step(776);
    chk("t4_xy776", 32'({if1.x, if1.y}), 32'hFF);
    stp = 1'b1;
    tick();
    stp = 1'b0;
    chk("t4_theta_hit", 32'(if1.theta), 32'd40);
    chk("t4_bounce_hi", 32'(if1.bounce), 32'd1);
    chk("t4_xy_held", 32'({if1.x, if1.y}), 32'hFF);
    tick();
    tick();
    chk("t4_one_bounce", 32'(n_bounce - b0), 32'd1);

    // Steps on the two clks after a theta change: first dropped, second taken.
    pulse_reset();
    pl1  = 4'd0;
    st1  = 6'd32;
    srv1 = 1'b1;
    tick();
    srv1 = 1'b0;
    stp  = 1'b1;
    tick();
    tick();
    stp = 1'b0;
    tick();
    chk("t5_x1", 32'(if1.x), 32'd7);
    do_step(67);
    chk("t5_x68", 32'(if1.x), 32'd7);
    do_step(1);
    chk("t5_x69", 32'(if1.x), 32'd6);
    chk("t5_y", 32'(if1.y), 32'd8);
    do_step(481);
    chk("t5_x550", 32'(if1.x), 32'd0);
    stp = 1'b1;
    tick();
    stp = 1'b0;
    chk("t5_goal_r", 32'(if1.goal_r), 32'd1);
    chk("t5_goal_l", 32'(if1.goal_l), 32'd0);
    chk("t5_active", 32'(if1.active), 32'd0);
    tick();

    // Curving every 4 accepted steps at zero speed.
    srv2 = 1'b1;
    tick();
    srv2 = 1'b0;
    tick();
    chk("t6_active", 32'(if2.active), 32'd1);
    do_step(3);
    chk("t6_theta3", 32'(if2.theta), 32'd0);
    do_step(1);
    chk("t6_theta4", 32'(if2.theta), 32'd1);
    chk("t6_xy", 32'({if2.x, if2.y}), 32'h88);
    do_step(4);
    chk("t6_theta8", 32'(if2.theta), 32'd2);
    chk("t6_d1_idle", 32'(if1.active), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("t6_arst_act", 32'(if2.active), 32'd0);
    chk("t6_arst_th", 32'(if2.theta), 32'd0);
    chk("t6_arst_xy", 32'({if2.x, if2.y}), 32'h88);
    tick();
    reset_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
